// File: rtl/cla_add_sched_pkg.sv
// Shared definitions for the nibble-serial CLA add sequencer.
//   state_t    : controller states
//   REQ_IDX_W  : width of a requester index (two requesters)
//   NIBBLES    : nibble count for the default 16-bit operand width
//   nibbles_of : nibble count for an arbitrary operand width
//   idx_w      : index width for a count, never narrower than one bit
package cla_add_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int REQ_IDX_W = 1;
  localparam int DEF_WIDTH = 16;
  localparam int NIBBLES   = DEF_WIDTH / 4;

  function automatic int nibbles_of(input int width);
    return width / 4;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_add_sched_arb.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (pointer returns to 0)
//   req        : request vector
//   en         : arbitration enable; grant is 0 when low
//   accept     : strobe; the pointer moves past the granted requester
//   grant      : one-hot (or zero) grant, combinational
module rr_arb2
  import cla_add_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant
);

  logic [REQ_IDX_W-1:0] ptr;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req[ptr])       grant[ptr]  = 1'b1;
      else if (req[~ptr]) grant[~ptr] = 1'b1;
    end
  end

  // Next favoured requester is the one that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= '0;
    else if (accept && |grant)  ptr <= ~grant[1];
  end

endmodule

// File: rtl/cla_add_sched.sv
// cla_add_sched: shares one registered 4-bit CLA slice between two requesters.
// Each accepted WIDTH-bit add is issued nibble by nibble (LSB first); the
// slice carry-out is fed back as the next carry-in and the sum is assembled
// and returned on a per-requester valid/ready response channel.
//   req_valid/req_ready          : request handshake (ready combinational, IDLE only)
//   req_a*/req_b*/req_cin*       : requester operands
//   rsp_valid/rsp_ready          : response handshake, owner bit only
//   rsp_sum/rsp_cout             : result, zero outside RESP
//   add_a/add_b/add_c0           : to the external adder slice
//   add_s/add_c4                 : from the slice, ADD_LAT cycles after sampling
//   busy                         : controller not idle
//
// state    | meaning
// IDLE     | arbitrating, waiting for a request
// ISSUE    | driving nibble i to the slice
// WAIT     | holding nibble i until the slice result is valid
// RESP     | presenting the result to the owner
module cla_add_sched
  import cla_add_sched_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic             req_cin0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic             req_cin1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c0,
  input  logic [3:0]       add_s,
  input  logic             add_c4,
  output logic             busy
);

  localparam int NIB   = nibbles_of(WIDTH);
  localparam int NIB_W = idx_w(NIB);
  localparam int CNT_W = idx_w(ADD_LAT + 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $fatal(1, "cla_add_sched: WIDTH must be a positive multiple of 4");
  end
  if (ADD_LAT < 1) begin : g_bad_lat
    $fatal(1, "cla_add_sched: ADD_LAT must be at least 1");
  end

  state_t                state_q, state_d;
  logic [REQ_IDX_W-1:0]  owner_q;
  logic [NIB-1:0][3:0]   a_q, b_q, sum_q;
  logic                  carry_q;
  logic [NIB_W-1:0]      nib_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            rsp_valid_q;
  logic [1:0]            grant;
  logic                  accept, expire, last_nib, rsp_done;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (state_q == ST_IDLE),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign expire    = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
  assign last_nib  = (nib_q == NIB_W'(NIB - 1));
  assign rsp_done  = (state_q == ST_RESP) && rsp_valid_q[owner_q] && rsp_ready[owner_q];

  always_comb begin
    state_d = state_q;
    add_a   = '0;
    add_b   = '0;
    add_c0  = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        add_a   = a_q[nib_q];
        add_b   = b_q[nib_q];
        add_c0  = carry_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        add_a  = a_q[nib_q];
        add_b  = b_q[nib_q];
        add_c0 = carry_q;
        if (expire) state_d = last_nib ? ST_RESP : ST_ISSUE;
      end
      ST_RESP:  if (rsp_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // carry_q is seeded with the request carry-in, so nibble 0 and later
  // nibbles share one carry path into the slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      nib_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: if (accept) begin
          owner_q <= grant[1];
          a_q     <= grant[1] ? req_a1   : req_a0;
          b_q     <= grant[1] ? req_b1   : req_b0;
          carry_q <= grant[1] ? req_cin1 : req_cin0;
          sum_q   <= '0;
          nib_q   <= '0;
        end
        ST_ISSUE: cnt_q <= CNT_W'(ADD_LAT);
        ST_WAIT: begin
          if (expire) begin
            sum_q[nib_q] <= add_s;
            carry_q      <= add_c4;
            if (!last_nib) nib_q <= nib_q + NIB_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // Response valid is registered: it rises one cycle after entering RESP.
        ST_RESP: if (!rsp_done) rsp_valid_q[owner_q] <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = (state_q == ST_RESP) ? sum_q : '0;
  assign rsp_cout  = (state_q == ST_RESP) && carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cla_add_sched.sv
module tb_cla_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1, rsp_sum;
  logic        req_cin0, req_cin1, rsp_cout, add_c0, add_c4, busy;
  logic [3:0]  add_a, add_b, add_s;

  logic [1:0]  req_valid_2, req_ready_2, rsp_valid_2, rsp_ready_2;
  logic [15:0] rsp_sum_2;
  logic        rsp_cout_2, add_c0_2, add_c4_2, busy_2;
  logic [3:0]  add_a_2, add_b_2, add_s_2;

  logic [4:0]  r1, r2a, r2b;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  cla_add_sched #(.WIDTH(16), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s), .add_c4(add_c4),
    .busy(busy));

  cla_add_sched #(.WIDTH(16), .ADD_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_2), .req_ready(req_ready_2),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready_2), .rsp_sum(rsp_sum_2), .rsp_cout(rsp_cout_2),
    .add_a(add_a_2), .add_b(add_b_2), .add_c0(add_c0_2), .add_s(add_s_2), .add_c4(add_c4_2),
    .busy(busy_2));

  // Registered 4-bit adder slice models: one and two cycles of latency.
  always_ff @(posedge clk) begin
    r1  <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};
    r2a <= {1'b0, add_a_2} + {1'b0, add_b_2} + {4'b0, add_c0_2};
    r2b <= r2a;
  end
  assign {add_c4, add_s}     = r1;
  assign {add_c4_2, add_s_2} = r2b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered #1+ after an edge with the DUT idle and the request presented.
  task automatic run_txn(input int own, input logic [15:0] a, input logic [15:0] exp_sum,
                         input logic exp_cout, input int stall, input logic c0_ones);
    int cyc;
    logic [1:0] oh;
    oh = 2'b01 << own;
    check("grant", {30'b0, req_ready}, {30'b0, oh});
    @(posedge clk); #1;
    check("add_a nib0", {28'b0, add_a}, {28'b0, a[3:0]});
    if (c0_ones) check("add_c0 nib0", {31'b0, add_c0}, 32'd1);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid == 2'b00) check("req_ready busy", {30'b0, req_ready}, 32'd0);
      if (cyc % 2 == 0 && cyc < 8) begin
        check("add_a seq", {28'b0, add_a}, {28'b0, 4'(a >> (2 * cyc))});
        if (c0_ones) check("add_c0 seq", {31'b0, add_c0}, 32'd1);
      end
    end
    check("latency", cyc, 32'd9);
    check("rsp_valid", {30'b0, rsp_valid}, {30'b0, oh});
    check("rsp_sum", {16'b0, rsp_sum}, {16'b0, exp_sum});
    check("rsp_cout", {31'b0, rsp_cout}, {31'b0, exp_cout});
    rsp_ready = ~oh;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall rsp_valid", {30'b0, rsp_valid}, {30'b0, oh});
      check("stall rsp_sum", {16'b0, rsp_sum}, {16'b0, exp_sum});
      check("stall req_ready", {30'b0, req_ready}, 32'd0);
      check("stall busy", {31'b0, busy}, 32'd1);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check("rsp_valid clr", {30'b0, rsp_valid}, 32'd0);
    check("rsp_sum clr", {16'b0, rsp_sum}, 32'd0);
    check("busy clr", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_valid_2 = 2'b00; rsp_ready_2 = 2'b00;
    req_a0 = '0; req_b0 = '0; req_cin0 = 1'b0;
    req_a1 = '0; req_b1 = '0; req_cin1 = 1'b0;
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("reset add_a", {28'b0, add_a}, 32'd0);
    check("reset rsp_sum", {16'b0, rsp_sum}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: both requesting; grants 0, 1, 0.
    req_a0 = 16'h0003; req_b0 = 16'h0004; req_cin0 = 1'b0;
    req_a1 = 16'h8000; req_b1 = 16'h8000; req_cin1 = 1'b0;
    req_valid = 2'b11; #1;
    run_txn(0, 16'h0003, 16'h0007, 1'b0, 0, 1'b0); #1;
    run_txn(1, 16'h8000, 16'h0000, 1'b1, 0, 1'b0); #1;
    run_txn(0, 16'h0003, 16'h0007, 1'b0, 0, 1'b0);
    req_valid = 2'b00;

    // Basic add on requester 0.
    req_a0 = 16'h1234; req_b0 = 16'h0FCD; req_cin0 = 1'b0;
    req_valid = 2'b01; #1;
    run_txn(0, 16'h1234, 16'h2201, 1'b0, 0, 1'b0);
    req_valid = 2'b00;

    // Full carry ripple on requester 1.
    req_a1 = 16'hFFFF; req_b1 = 16'h0000; req_cin1 = 1'b1;
    req_valid = 2'b10; #1;
    run_txn(1, 16'hFFFF, 16'h0000, 1'b1, 0, 1'b1);
    req_valid = 2'b00;

    // Back-pressure: five stalled RESP cycles, non-owner ready asserted.
    req_a0 = 16'h1234; req_b0 = 16'h0FCD; req_cin0 = 1'b1;
    req_valid = 2'b01; #1;
    run_txn(0, 16'h1234, 16'h2202, 1'b0, 5, 1'b0);
    req_valid = 2'b00;

    // Reset during WAIT of nibble 2 (pointer is 1 at this point).
    req_cin0 = 1'b0;
    req_valid = 2'b01; #1;
    check("rst grant", {30'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check("midop busy", {31'b0, busy}, 32'd1);
    check("midop add_a", {28'b0, add_a}, 32'd2);
    rst_n = 1'b0; #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst add_a", {28'b0, add_a}, 32'd0);
    check("rst add_b", {28'b0, add_b}, 32'd0);
    check("rst add_c0", {31'b0, add_c0}, 32'd0);
    check("rst rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("rst rsp_sum", {16'b0, rsp_sum}, 32'd0);
    check("rst rsp_cout", {31'b0, rsp_cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("no rsp after rst", {29'b0, busy, rsp_valid}, 32'd0);
    end
    req_a1 = 16'h00FF; req_b1 = 16'h0001; req_cin1 = 1'b0;
    req_valid = 2'b11; #1;
    check("ptr after rst", {30'b0, req_ready}, 32'd1);
    req_valid = 2'b10; #1;
    run_txn(1, 16'h00FF, 16'h0100, 1'b0, 0, 1'b0);
    req_valid = 2'b00;

    // ADD_LAT=2 instance.
    req_a0 = 16'h1234; req_b0 = 16'h0FCD; req_cin0 = 1'b0;
    req_valid_2 = 2'b01; #1;
    check("l2 grant", {30'b0, req_ready_2}, 32'd1);
    @(posedge clk); #1;
    req_valid_2 = 2'b00;
    cyc = 0;
    while (rsp_valid_2 == 2'b00 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("l2 latency", cyc, 32'd13);
    check("l2 rsp_valid", {30'b0, rsp_valid_2}, 32'd1);
    check("l2 rsp_sum", {16'b0, rsp_sum_2}, 32'h2201);
    check("l2 rsp_cout", {31'b0, rsp_cout_2}, 32'd0);
    rsp_ready_2 = 2'b01;
    @(posedge clk); #1;
    rsp_ready_2 = 2'b00;
    check("l2 rsp_valid clr", {30'b0, rsp_valid_2}, 32'd0);
    check("l2 busy clr", {31'b0, busy_2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
